// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver with a two-flop
// synchroniser, 2-of-3 majority voting, false-start rejection and a
// valid/ready output with sticky overrun.
// Build macro UART_RX_FIFO_EN: completed frames are queued in a
// FIFO_DEPTH-entry FIFO instead of a single output register.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic                 rxd,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_perror,
  output logic                 rx_ferror,
  output logic                 rx_overrun,
  output logic                 rx_busy
);
  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam int N_W  = $clog2(DATA_BITS);
  localparam int M    = OVERSAMPLE / 2;
  localparam logic [SC_W-1:0] SC_MA   = SC_W'(M - 1);
  localparam logic [SC_W-1:0] SC_MB   = SC_W'(M);
  localparam logic [SC_W-1:0] SC_MC   = SC_W'(M + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [N_W-1:0]  N_LAST  = N_W'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || OVERSAMPLE > 32 ||
      (OVERSAMPLE % 2) != 0 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_rx_param: illegal parameter value");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic                   sync_q, rxs_q;
  logic [DIV_W-1:0]       tcnt_q, tcnt_d, div_q, div_d, div_eff;
  logic                   tick, decide, wrap, maj, exp_par;
  logic [SC_W-1:0]        sc_q, sc_d;
  logic [N_W-1:0]         n_q, n_d;
  logic                   stop_n_q, stop_n_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   v0_q, v0_d, v1_q, v1_d;
  logic                   perr_q, perr_d, ferr_q, ferr_d;
  logic [1:0]             pmode_q, pmode_d;
  logic                   done_q, done_d;

  // Two-flop synchroniser on the asynchronous line; idles high
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      sync_q <= rxd;
      rxs_q  <= sync_q;
    end
  end

  // Tick generator; the divisor follows baud_div until the frame leaves START
  always_comb begin
    div_d   = (state_q == S_IDLE || state_q == S_START) ? baud_div : div_q;
    div_eff = (div_d == '0) ? DIV_W'(1) : div_d;
    tick    = rx_en && (tcnt_q >= div_eff - DIV_W'(1));
    tcnt_d  = (!rx_en || tick) ? '0 : tcnt_q + DIV_W'(1);
    decide  = tick && (sc_q == SC_MC);
    wrap    = tick && (sc_q == SC_LAST);
    maj     = (v0_q & v1_q) | (v0_q & rxs_q) | (v1_q & rxs_q);
    exp_par = (^shreg_q) ^ pmode_q[1];
  end

  // Frame FSM: next state, sample counter, shift register and pending flags
  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    n_d      = n_q;
    stop_n_d = stop_n_q;
    shreg_d  = shreg_q;
    v0_d     = v0_q;
    v1_d     = v1_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    pmode_d  = pmode_q;
    done_d   = 1'b0;
    if (tick) sc_d = (sc_q == SC_LAST) ? '0 : sc_q + SC_W'(1);
    if (tick && sc_q == SC_MA) v0_d = rxs_q;
    if (tick && sc_q == SC_MB) v1_d = rxs_q;
    unique case (state_q)
      S_IDLE: begin
        if (tick && !rxs_q) begin
          state_d = S_START;
          sc_d    = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (decide && maj) begin
          state_d = S_IDLE;
          sc_d    = '0;
        end else if (wrap) begin
          state_d = S_DATA;
          sc_d    = '0;
          n_d     = '0;
          pmode_d = parity_mode;
        end
      end
      S_DATA: begin
        if (decide) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (n_q == N_LAST) begin
            state_d  = (pmode_q[0] ^ pmode_q[1]) ? S_PARITY : S_STOP;
            sc_d     = '0;
            stop_n_d = 1'b0;
          end else begin
            n_d = n_q + N_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (decide && (maj != exp_par)) perr_d = 1'b1;
        if (wrap) begin
          state_d  = S_STOP;
          sc_d     = '0;
          stop_n_d = 1'b0;
        end
      end
      S_STOP: begin
        if (decide) begin
          if (!maj) ferr_d = 1'b1;
          // Leave at the final decision so the next start edge is not missed
          if (stop_n_q == 1'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            sc_d    = '0;
            done_d  = 1'b1;
          end
        end else if (wrap) begin
          stop_n_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!rx_en) begin
      state_d = S_IDLE;
      sc_d    = '0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Receive-path state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tcnt_q   <= '0;
      div_q    <= '0;
      sc_q     <= '0;
      n_q      <= '0;
      stop_n_q <= 1'b0;
      shreg_q  <= '0;
      v0_q     <= 1'b1;
      v1_q     <= 1'b1;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      pmode_q  <= 2'b00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      div_q    <= div_d;
      sc_q     <= sc_d;
      n_q      <= n_d;
      stop_n_q <= stop_n_d;
      shreg_q  <= shreg_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      pmode_q  <= pmode_d;
      done_q   <= done_d;
    end
  end

  assign rx_busy = (state_q != S_IDLE);

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_BITS+1:0] fifo_mem [FIFO_DEPTH];
  logic [DATA_BITS+1:0] head;
  logic [AW:0]          wp_q, wp_d, rp_q, rp_d;
  logic                 ovr_q, ovr_d, empty, full, pop, push;

  // FIFO pointers and overrun; the head is read combinationally so a pop
  // presents the next word immediately
  always_comb begin
    empty = (wp_q == rp_q);
    full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    pop   = !empty && rx_ready;
    push  = done_q && (!full || pop);
    wp_d  = push ? wp_q + (AW+1)'(1) : wp_q;
    rp_d  = pop ? rp_q + (AW+1)'(1) : rp_q;
    ovr_d = ovr_q;
    if (done_q && !push) ovr_d = 1'b1;
    if (pop) ovr_d = 1'b0;
    head  = empty ? '0 : fifo_mem[rp_q[AW-1:0]];
  end

  // FIFO storage, written on push
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wp_q[AW-1:0]] <= {ferr_q, perr_q, shreg_q};
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovr_q <= ovr_d;
    end
  end

  assign rx_valid   = !empty;
  assign rx_data    = head[DATA_BITS-1:0];
  assign rx_perror  = head[DATA_BITS];
  assign rx_ferror  = head[DATA_BITS+1];
  assign rx_overrun = ovr_q;
`else
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;
  logic                 accept;

  // Single output register with valid/ready handshake and drop-on-full
  always_comb begin
    rdata_d = rdata_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    accept  = valid_q && rx_ready;
    if (done_q && (!valid_q || rx_ready)) begin
      rdata_d = shreg_q;
      pe_d    = perr_q;
      fe_d    = ferr_q;
      valid_d = 1'b1;
    end else begin
      if (done_q) ovr_d = 1'b1;
      if (accept) valid_d = 1'b0;
      if (!valid_d) begin
        pe_d = 1'b0;
        fe_d = 1'b0;
      end
    end
    if (accept) ovr_d = 1'b0;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data    = rdata_q;
  assign rx_valid   = valid_q;
  assign rx_perror  = pe_q;
  assign rx_ferror  = fe_q;
  assign rx_overrun = ovr_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param (default parameters: 8 data bits,
// 16x oversampling, one stop bit). Serial frames are built from plain
// line-level rules; expected words come from a table and a small model.
module tb_uart_rx_param;
  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_en = 1'b1;
  logic        rxd = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic [1:0]  parity_mode = 2'b00;
  logic        rx_ready = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_perror, rx_ferror, rx_overrun, rx_busy;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_lat = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rx_word_t;

  rx_word_t got_q[$];
  int       got_cyc[$];

  typedef struct {
    logic [7:0] d;
    logic [1:0] pm;
    logic       has_par;
    logic       par_bit;
    logic       stop_bit;
    int         glitch;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[8];

  uart_rx_param dut (
    .clk(clk), .reset(reset), .rx_en(rx_en), .rxd(rxd), .baud_div(baud_div),
    .parity_mode(parity_mode), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_perror(rx_perror), .rx_ferror(rx_ferror),
    .rx_overrun(rx_overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted word, sampled away from the active edge
  always @(negedge clk) begin
    if (!reset && rx_valid && rx_ready) begin
      got_q.push_back('{d: rx_data, pe: rx_perror, fe: rx_ferror});
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int bit_time();
    return OS * ((baud_div == 16'd0) ? 1 : int'(baud_div));
  endfunction

  // Reference parity rule: even -> bit equals XOR of data, odd -> its inverse
  function automatic logic model_perr(input logic [7:0] d, input logic [1:0] pm, input logic pb);
    case (pm)
      2'b01:   return pb != (^d);
      2'b10:   return pb != ~(^d);
      default: return 1'b0;
    endcase
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                            input logic stop_bit, input int glitch, input logic scramble);
    int bt, g;
    bt = bit_time();
    g  = (baud_div == 16'd0) ? 1 : int'(baud_div);
    @(posedge clk);
    rxd = 1'b0;
    start_cyc = cyc;
    repeat (bt) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      if (scramble && i == 2) parity_mode = 2'($urandom);
      if (i == glitch) begin
        repeat (bt / 2 - g / 2) @(posedge clk);
        rxd = ~d[i];
        repeat (g) @(posedge clk);
        rxd = d[i];
        repeat (bt - bt / 2 + g / 2 - g) @(posedge clk);
      end else begin
        repeat (bt) @(posedge clk);
      end
    end
    if (has_par) begin
      rxd = par_bit;
      repeat (bt) @(posedge clk);
    end
    rxd = stop_bit;
    repeat (bt) @(posedge clk);
    rxd = 1'b1;
    repeat (2 * bt) @(posedge clk);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    int bt;
    bt = bit_time();
    @(posedge clk);
    rxd = 1'b0;
    repeat (bt) @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      rxd = d[i];
      repeat (bt) @(posedge clk);
    end
  endtask

  task automatic expect_word(input string tag, input logic [7:0] ed, input logic epe, input logic efe);
    rx_word_t w;
    int c;
    check({tag, "_count"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      w = got_q.pop_front();
      c = got_cyc.pop_front();
      last_lat = c - start_cyc;
      check({tag, "_data"}, w.d, ed);
      check({tag, "_perr"}, w.pe, epe);
      check({tag, "_ferr"}, w.fe, efe);
    end
    got_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    vecs[0] = '{8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, -1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 2'd1, 1'b1, 1'b1, 1'b1, -1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 2'd2, 1'b1, 1'b1, 1'b1, -1, 8'h3C, 1'b0, 1'b0};
    vecs[3] = '{8'h55, 2'd0, 1'b0, 1'b0, 1'b0, -1, 8'h55, 1'b0, 1'b1};
    vecs[4] = '{8'h0F, 2'd0, 1'b0, 1'b0, 1'b1, -1, 8'h0F, 1'b0, 1'b0};
    vecs[5] = '{8'h96, 2'd0, 1'b0, 1'b0, 1'b1,  3, 8'h96, 1'b0, 1'b0};
    vecs[6] = '{8'h81, 2'd3, 1'b0, 1'b0, 1'b1,  5, 8'h81, 1'b0, 1'b0};
    vecs[7] = '{8'hE7, 2'd1, 1'b1, 1'b0, 1'b0, -1, 8'hE7, 1'b0, 1'b1};

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_flags", {rx_perror, rx_ferror, rx_overrun, rx_busy}, 0);
    reset = 1'b0;
    repeat (8) @(posedge clk);

    // Table-driven frames
    for (int k = 0; k < 8; k++) begin
      parity_mode = vecs[k].pm;
      send_frame(vecs[k].d, vecs[k].has_par, vecs[k].par_bit, vecs[k].stop_bit,
                 vecs[k].glitch, 1'b0);
      expect_word($sformatf("vec%0d", k), vecs[k].exp_d, vecs[k].exp_pe, vecs[k].exp_fe);
      if (k == 0) check("latency_le_640", last_lat <= 640, 1);
    end

    // False start: line low for four ticks only
    parity_mode = 2'b00;
    @(posedge clk);
    rxd = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("fstart_busy_hi", rx_busy, 1);
    rxd = 1'b1;
    repeat (2 * bit_time()) @(posedge clk);
    @(negedge clk);
    check("fstart_busy_lo", rx_busy, 0);
    check("fstart_no_word", got_q.size(), 0);

    // Randomised frames against the reference model
    for (int r = 0; r < 16; r++) begin
      logic [7:0] d;
      logic [1:0] pm;
      logic       pb, sb, hp;
      d  = 8'($urandom);
      pm = 2'($urandom);
      pb = 1'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      hp = (pm == 2'b01 || pm == 2'b10);
      baud_div = 16'($urandom_range(0, 5));
      parity_mode = pm;
      send_frame(d, hp, pb, sb, -1, 1'b1);
      expect_word($sformatf("rand%0d", r), d, model_perr(d, pm, pb), !sb);
    end
    baud_div = 16'd4;
    parity_mode = 2'b00;
    repeat (2 * bit_time()) @(posedge clk);

`ifdef UART_RX_FIFO_EN
    // Five frames with no reads: four stored, fifth dropped
    rx_ready = 1'b0;
    for (int f = 0; f < 5; f++) send_frame(8'(8'h11 * (f + 1)), 1'b0, 1'b0, 1'b1, -1, 1'b0);
    @(negedge clk);
    check("fifo_overrun_set", rx_overrun, 1);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("fifo_valid%0d", j), rx_valid, 1);
      check($sformatf("fifo_data%0d", j), rx_data, 8'(8'h11 * (j + 1)));
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    check("fifo_empty", rx_valid, 0);
    check("fifo_overrun_clr", rx_overrun, 0);
`else
    // Overrun: second frame dropped while the first is unread
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    @(negedge clk);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_flag", rx_overrun, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("ovr_valid_clr", rx_valid, 0);
    check("ovr_flag_clr", rx_overrun, 0);
`endif
    got_q.delete();
    got_cyc.delete();

    // Reset in the middle of DATA with a held word and overrun pending
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    send_frame(8'h78, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    send_frame(8'h79, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    send_frame(8'h7A, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    send_frame(8'h7B, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    @(negedge clk);
    check("pre_rst_overrun", rx_overrun, 1);
    send_partial(8'h5A, 3);
    @(negedge clk);
    check("pre_rst_busy", rx_busy, 1);
    reset = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_valid", rx_valid, 0);
    check("rst_mid_data", rx_data, 0);
    check("rst_mid_flags", {rx_perror, rx_ferror, rx_overrun, rx_busy}, 0);
    rx_ready = 1'b1;
    got_q.delete();
    got_cyc.delete();
    repeat (bit_time()) @(posedge clk);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    expect_word("after_rst", 8'hC3, 1'b0, 1'b0);

    // Abort by rx_en pulse in the middle of DATA
    send_partial(8'h5A, 3);
    @(negedge clk);
    rx_en = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    rx_en = 1'b1;
    check("en_abort_busy", rx_busy, 0);
    repeat (12 * bit_time()) @(posedge clk);
    check("en_abort_no_word", got_q.size(), 0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    expect_word("after_en", 8'hC3, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised, oversampling UART receiver; next generation of the fixed 8-bit receiver in the UART subsystem. Configurable data width, oversampling ratio and stop-bit count, with runtime parity mode and baud divisor. Includes a two-flop input synchroniser, three-sample majority voting, false-start rejection and a valid/ready output handshake with overrun detection. Sits between the RxD pad and the system-side consumer (register file or DMA).

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first on the line
OVERSAMPLE, 16, sample ticks per bit, even, legal 8..32
STOP_BITS, 1, stop bits checked, 1 or 2
DIV_W, 16, width of baud_div
FIFO_DEPTH, 4, output FIFO entries, power of 2; used only with UART_RX_FIFO_EN

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_en  in  1  receiver enable; low aborts any frame in progress
rxd  in  1  asynchronous serial input, idle high
baud_div  in  DIV_W  clk cycles per sample tick; 0 treated as 1
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
rx_data  out  DATA_BITS  received word
rx_valid  out  1  rx_data and error flags valid
rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready
rx_perror  out  1  parity error for the presented word
rx_ferror  out  1  framing error (any stop bit sampled 0) for the presented word
rx_overrun  out  1  sticky; a completed frame was dropped
rx_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (clk edge with reset=1): all outputs 0, rx_data 0, FSM IDLE, tick and sample counters 0, synchroniser flops 1.
- rxd passes through two flops (rxs) before any use. The tick counter counts clk cycles and pulses tick for one cycle every max(baud_div,1) cycles. It free-runs while rx_en=1 and is held at 0 while rx_en=0.
- Sample counter sc runs 0..OVERSAMPLE-1 on ticks and is cleared on every state entry. Majority bit = 2-of-3 of rxs at sc = M-1, M, M+1, where M = OVERSAMPLE/2. The bit decision is taken on the tick at sc = M+1.
- States and transitions:
  - IDLE: rxs=0 on a tick -> START.
  - START: at decision, majority 1 -> IDLE (false start); majority 0 -> DATA at sc wrap.
  - DATA: shift majority into bit n (n = 0..DATA_BITS-1) at each decision; after the last bit wraps, go to PARITY if parity enabled, else STOP.
  - PARITY: compare majority with the expected bit. Even: XOR of data bits. Odd: its inverse. Mismatch -> perror_pending.
  - STOP: at each stop-bit decision, majority 0 -> ferror_pending. After the final stop decision go straight to IDLE (do not wait for sc wrap), so a start bit in the next half-bit is caught.
- Frame completion happens on the cycle after the final stop decision:
  - If rx_valid=0 or rx_ready=1: load rx_data, rx_perror and rx_ferror from the pending values and set rx_valid=1.
  - Otherwise: keep the old word, set rx_overrun=1, discard the new frame.
- Handshake:
  - rx_valid stays high until a cycle with rx_ready=1. Accept and load in the same cycle leaves rx_valid=1 with the new word.
  - rx_valid=0 with no load clears rx_perror and rx_ferror.
  - rx_overrun clears only on reset or on an accepted transfer.
- rx_en=0: FSM to IDLE on the next edge, pending flags cleared, partial frame discarded. Output registers and handshake continue to operate.
- parity_mode and baud_div are sampled at the START->DATA transition. Changes mid-frame do not affect that frame.
- DATA_BITS=9: rx_data[8] is the MSB (last data bit on the line).

Optional Feature:
UART_RX_FIFO_EN
- Defined: completed frames are written as {ferror, perror, data} into a FIFO_DEPTH-entry FIFO. The outputs present the FIFO head, and rx_valid = FIFO not empty. Overrun is set only when a frame completes while the FIFO is full and not popped in the same cycle. Pop and push in the same cycle is legal when full.
- Undefined: single output register as described in Behaviour.

Test Plan:
- 8N1, OVERSAMPLE=16, baud_div=4, parity none, rx_ready=1, send 0xA5 -> one rx_valid pulse, rx_data=0xA5, perror=0, ferror=0. rx_valid rises within 10 bit times (640 clk) of the start edge.
- Even parity, send 0x3C with parity bit 1 (wrong) -> rx_data=0x3C, rx_perror=1. Odd parity, same line -> rx_perror=0.
- Send 0x55 with stop bit driven 0 -> rx_ferror=1, rx_data=0x55. Next correct frame 0x0F -> rx_ferror=0.
- rxd low for 4 ticks only -> FSM returns to IDLE, rx_busy drops, no rx_valid. Single-tick glitch at sc=M inside a data bit -> bit still decoded correctly.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, rx_overrun=1. Raise rx_ready one cycle -> rx_valid=0, overrun=0. With UART_RX_FIFO_EN and depth 4: five frames with no reads -> four stored, overrun=1.
- Assert reset mid-DATA, then deassert -> all outputs 0, FSM IDLE. Next frame 0xC3 is received cleanly. Repeat with rx_en pulsed low instead of reset -> same result.
